risc_v_mike_uart_boot_loader: RTL
=================================

Name: risc_v_mike_uart_boot_loader

Overview:
- Loads a program image into instruction memory over a UART serial line, replacing testbench backdoor writes to the instruction memory array.
- Holds the core in reset until the load finishes.
- Receives bytes, assembles them into little-endian words, and writes each word to consecutive instruction memory addresses starting at START_ADDR.
- Sits between the board rx pin and the instruction memory write port, inside risc_v_mike_top.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Minimum 4.
- DATA_WIDTH, 32, instruction word width; multiple of 8.
- ADDR_WIDTH, 10, instruction memory word-address width.
- START_ADDR, 2, word address of the first written instruction.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- rx  in  1  UART serial input; idle high; asynchronous to clk
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_waddr  out  ADDR_WIDTH  word address for the write
- imem_wdata  out  DATA_WIDTH  assembled word
- core_hold  out  1  1 = keep the core in reset
- done  out  1  load complete; sticky
- frame_err  out  1  stop-bit error or checksum error; sticky

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset values: imem_we=0, imem_waddr=START_ADDR, imem_wdata=0, core_hold=1, done=0, frame_err=0. All internal counters are cleared.
- Asserting rst mid-load aborts the load. Any partial word is discarded and the FSM restarts at LEN_LO.
- rx passes through a 2-FF synchronizer that resets to 1.

RX sub-FSM (IDLE, START, DATA, STOP):
- IDLE→START on a synchronized falling edge.
- START re-samples rx at CLKS_PER_BIT/2. If rx=1, the edge is treated as a glitch and the FSM returns to IDLE.
- DATA samples 8 bits LSB-first, one every CLKS_PER_BIT at mid-bit.
- STOP samples at mid-bit:
  - rx=1: byte_valid pulses for 1 cycle.
  - rx=0: frame_err=1 and the byte is discarded.
- Either way the FSM returns to IDLE.

Loader FSM (LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR):
- LEN_LO: on byte_valid, capture word count bits [7:0].
- LEN_HI: on byte_valid, capture bits [15:8]. If count=0, go to DONE; otherwise go to DATA.
- DATA: shift bytes into the word little-endian (first byte → [7:0]). After DATA_WIDTH/8 bytes, go to WRITE.
- WRITE: imem_we=1 for exactly one cycle, with the addr/data valid that same cycle. This cycle is the one after the last byte's byte_valid. Then:
  - Decrement count and increment the address.
  - If count reaches 0, go to DONE; otherwise go to DATA.
- Address increments modulo 2^ADDR_WIDTH; it wraps with no error.
- DONE: core_hold=0 and done=1 from the cycle after entry. rx is ignored until rst.
- ERROR: entered on any frame_err. core_hold stays 1, imem_we stays 0, and all further bytes are ignored until rst.
- Byte throughput is far below one per cycle, so WRITE can never collide with a new byte_valid.

Optional Feature:
- Macro: UART_BOOT_CHECKSUM_EN.
- Defined:
  - After the last data word, the loader expects one extra checksum byte: the XOR of all data bytes, excluding the length bytes.
  - Match: go to DONE.
  - Mismatch: frame_err=1, go to ERROR; core_hold stays 1.
  - With count=0, the checksum byte is still required and must be 0x00.
  - Words are still written as they complete, before the checksum is checked.
- Undefined: there is no checksum byte, and DONE follows the last WRITE directly.

Test Plan:
- CLKS_PER_BIT=4. Send 02 00 93 00 20 00 13 01 40 00 → writes (addr 2, 0x00200093) then (addr 3, 0x00400113), one cycle each. done=1, core_hold=0, frame_err=0.
- Send 00 00 → no imem_we. done=1 the cycle after the stop bit. Later bytes cause no writes.
- Send 01 00, then a data byte with stop bit=0 → frame_err=1, core_hold=1, no imem_we. A following valid word is ignored.
- 1-cycle low glitch on rx while in IDLE → no byte_valid and no state change. A subsequent valid load succeeds.
- Assert rst after 2 of 4 data bytes, release, then send the full 01 00 6f f0 9f ff → a single write (addr 2, 0xff9ff06f). No stale bytes.
- UART_BOOT_CHECKSUM_EN: 01 00 93 00 20 00 B3 → done=1. Same with checksum 00 → frame_err=1, core_hold=1, with the word at addr 2 already written.

Source files
------------

// File: rtl/risc_v_mike_uart_boot_loader.sv
// risc_v_mike_uart_boot_loader: UART program loader that fills instruction memory and holds the core in reset until done
// Ports: clk, rst (sync, active-high); rx (async UART in, idle high);
//   imem_we/imem_waddr/imem_wdata (instruction memory write port, one cycle per word);
//   core_hold (1 = core in reset); done (sticky load complete); frame_err (sticky stop-bit/checksum error).
// Image format: 16-bit little-endian word count, then count little-endian words.
// Optional macro UART_BOOT_CHECKSUM_EN: a trailing XOR-of-data-bytes checksum byte is required before done.
module risc_v_mike_uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int START_ADDR   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  frame_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [2:0] {L_LEN_LO, L_LEN_HI, L_DATA, L_WRITE, L_DONE, L_ERROR, L_CSUM} ld_t;
`ifdef UART_BOOT_CHECKSUM_EN
  localparam ld_t FIN = L_CSUM;
`else
  localparam ld_t FIN = L_DONE;
`endif
  logic [2:0]            rx_sync_q, rx_sync_d;
  rx_t                   rx_st_q, rx_st_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  stop_err_q, stop_err_d;
  ld_t                   ld_st_q, ld_st_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [7:0]            byte_cnt_q, byte_cnt_d;
  logic                  err_q, err_d;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif
  logic rxs, fall, tick;
  assign rxs  = rx_sync_q[1];
  assign fall = rx_sync_q[2] & ~rx_sync_q[1];
  assign tick = clk_cnt_q == CW'(CLKS_PER_BIT - 1);
  always_comb begin
    rx_sync_d    = {rx_sync_q[1:0], rx};
    rx_st_d      = rx_st_q;
    clk_cnt_d    = clk_cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    stop_err_d   = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        clk_cnt_d = '0;
        rx_st_d   = fall ? R_START : R_IDLE;
      end
      R_START: if (clk_cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
        rx_st_d   = rxs ? R_IDLE : R_DATA;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
      R_DATA: if (tick) begin
        clk_cnt_d = '0;
        shift_d   = {rxs, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        rx_st_d   = bit_cnt_q == 3'd7 ? R_STOP : R_DATA;
      end
      default: if (tick) begin
        clk_cnt_d    = '0;
        byte_valid_d = rxs;
        stop_err_d   = ~rxs;
        rx_st_d      = R_IDLE;
      end
    endcase
  end
  always_comb begin
    ld_st_d    = ld_st_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = err_q;
`ifdef UART_BOOT_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (stop_err_q && ld_st_q != L_DONE && ld_st_q != L_ERROR) begin
      err_d   = 1'b1;
      ld_st_d = L_ERROR;
    end else if (ld_st_q == L_WRITE) begin
      cnt_d   = cnt_q - 16'd1;
      addr_d  = addr_q + 1'b1;
      ld_st_d = cnt_q == 16'd1 ? FIN : L_DATA;
    end else if (byte_valid_q) begin
      case (ld_st_q)
        L_LEN_LO: begin
          cnt_d   = {8'h00, shift_q};
          ld_st_d = L_LEN_HI;
        end
        L_LEN_HI: begin
          cnt_d   = {shift_q, cnt_q[7:0]};
          ld_st_d = {shift_q, cnt_q[7:0]} == 16'd0 ? FIN : L_DATA;
        end
        L_DATA: begin
          word_d     = {shift_q, word_q[DATA_WIDTH-1:8]};
          byte_cnt_d = byte_cnt_q == 8'(NB - 1) ? 8'd0 : byte_cnt_q + 8'd1;
          ld_st_d    = byte_cnt_q == 8'(NB - 1) ? L_WRITE : L_DATA;
`ifdef UART_BOOT_CHECKSUM_EN
          csum_d     = csum_q ^ shift_q;
`endif
        end
`ifdef UART_BOOT_CHECKSUM_EN
        L_CSUM: begin
          err_d   = shift_q != csum_q;
          ld_st_d = shift_q == csum_q ? L_DONE : L_ERROR;
        end
`endif
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q    <= 3'b111;
      rx_st_q      <= R_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      stop_err_q   <= 1'b0;
      ld_st_q      <= L_LEN_LO;
      cnt_q        <= '0;
      addr_q       <= ADDR_WIDTH'(START_ADDR);
      word_q       <= '0;
      byte_cnt_q   <= '0;
      err_q        <= 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      rx_sync_q    <= rx_sync_d;
      rx_st_q      <= rx_st_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      stop_err_q   <= stop_err_d;
      ld_st_q      <= ld_st_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      err_q        <= err_d;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end
  assign imem_we    = ld_st_q == L_WRITE;
  assign imem_waddr = addr_q;
  assign imem_wdata = word_q;
  assign core_hold  = ld_st_q != L_DONE;
  assign done       = ld_st_q == L_DONE;
  assign frame_err  = err_q;
endmodule
